alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream issue stage for the 8-bit combinational ALU (ports a, b, cl, out).
//  Buffers operand/opcode commands in a DEPTH-entry FIFO and issues one at a time.
//  Drives the ALU from registered operands and captures the result one cycle later.
//  Returns each result with its opcode over a valid/ready response port, in order.
// PARAMETERS
//  DATA_W  8  operand/result width; must match the ALU
//  OP_W    4  opcode width; must match the ALU cl
//  DEPTH   4  command FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1                   rising-edge clock
//  rst        in   1                   synchronous, active-high reset
//  cmd_valid  in   1                   command present
//  cmd_ready  out  1                   command accepted when cmd_valid&cmd_ready at edge
//  cmd_a      in   DATA_W              operand a
//  cmd_b      in   DATA_W              operand b
//  cmd_op     in   OP_W                ALU opcode
//  alu_a      out  DATA_W              registered operand to ALU a
//  alu_b      out  DATA_W              registered operand to ALU b
//  alu_cl     out  OP_W                registered opcode to ALU cl
//  alu_out    in   DATA_W              ALU combinational result
//  rsp_valid  out  1                   result available
//  rsp_ready  in   1                   consumer takes result when rsp_valid&rsp_ready
//  rsp_data   out  DATA_W              captured result
//  rsp_op     out  OP_W                opcode that produced rsp_data
//  rsp_err    out  1                   1 = divide by zero (op 4'b0011, b==0)
//  count      out  $clog2(DEPTH+1)     FIFO occupancy (excludes in-flight command)
//  busy       out  1                   state!=IDLE or count!=0
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, FIFO pointers/count=0, alu_a/alu_b/alu_cl=0,
//   rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0. FIFO contents and in-flight work discarded.
//   cmd_ready=0 while rst=1. Reset wins over every simultaneous event.
//  cmd_ready = !rst && (count!=DEPTH); combinational, no full-FIFO bypass.
//   A push into a full FIFO is refused even if a pop occurs in the same cycle.
//  Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
//  FSM:
//   IDLE:  count!=0 -> pop head into alu_a/alu_b/alu_cl; go ISSUE. Else stay.
//   ISSUE: ALU settles. At edge: rsp_data<=alu_out, rsp_op<=alu_cl,
//          rsp_err<=(alu_cl==4'b0011 && alu_b==0), rsp_valid<=1; go HOLD.
//          On rsp_err=1, rsp_data<=all ones (8'hFF) instead of alu_out.
//   HOLD:  rsp_valid=1 and rsp_data/op/err stay stable until the handshake.
//          On rsp_ready=1: rsp_valid<=0. If count!=0, pop next and go ISSUE;
//          else go IDLE. With rsp_ready=0, stay.
//  Latency (empty, idle): command accepted at edge T, popped at T+1, rsp_valid=1 after T+2.
//  Throughput: one result every 2 cycles with rsp_ready held high.
//  alu_a/alu_b/alu_cl change only on a pop; they hold their value in IDLE and HOLD.
//  Capacity: DEPTH queued plus 1 in flight.
//  Ordering: strict FIFO; results are never reordered or dropped.
// TESTING
//  Reset: hold rst 2 cycles -> rsp_valid=0, count=0, alu_cl=0, busy=0; cmd_ready=1 after release.
//  Single op: a=20, b=22, op=0000 at edge T -> rsp_valid after T+2; rsp_data=42, rsp_op=0, rsp_err=0.
//  Fill: rsp_ready=0, push 6 cmds back-to-back -> 5 accepted, count=4, cmd_ready=0, 6th held.
//  Drain: then rsp_ready=1 -> 5 results in push order, one every 2 cycles; busy=0 at end.
//  Div by zero: a=9, b=0, op=0011 -> rsp_data=8'hFF, rsp_err=1; next op a=9, b=3, op=0011 -> 3, err=0.
//  Mid-op reset: rst in HOLD with count=3 -> next cycle rsp_valid=0, count=0, state IDLE; no stale results.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for an external combinational ALU: queues commands in a small FIFO,
// drives the ALU from registered operands and returns each result over valid/ready.
//
// state | meaning
// IDLE  | nothing in flight; waiting for a queued command
// ISSUE | operands on ALU ports, result settling; captured at the next edge
// HOLD  | result presented on rsp_*; waiting for rsp_ready
module alu_cmd_sequencer #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [DATA_W-1:0]            cmd_a,
   input  logic [DATA_W-1:0]            cmd_b,
   input  logic [OP_W-1:0]              cmd_op,
   output logic [DATA_W-1:0]            alu_a,
   output logic [DATA_W-1:0]            alu_b,
   output logic [OP_W-1:0]              alu_cl,
   input  logic [DATA_W-1:0]            alu_out,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_W-1:0]            rsp_data,
   output logic [OP_W-1:0]              rsp_op,
   output logic                         rsp_err,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem_a  [DEPTH];
   logic [DATA_W-1:0] mem_b  [DEPTH];
   logic [OP_W-1:0]   mem_op [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;

   logic push, pop, div_zero;

   assign cmd_ready = !rst && (count != CNT_W'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state != S_IDLE) || (count != '0);
   assign div_zero  = (alu_cl == OP_DIV) && (alu_b == '0);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = S_HOLD;
         S_HOLD: begin
            if (rsp_ready) begin
               if (count != '0) begin
                  pop       = 1'b1;
                  state_nxt = S_ISSUE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_cl    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_op    <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (pop) begin
            alu_a  <= mem_a[rd_ptr];
            alu_b  <= mem_b[rd_ptr];
            alu_cl <= mem_op[rd_ptr];
         end
         if (state == S_ISSUE) begin
            rsp_valid <= 1'b1;
            rsp_op    <= alu_cl;
            rsp_err   <= div_zero;
            rsp_data  <= div_zero ? '1 : alu_out;
         end else if ((state == S_HOLD) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a behavioural ALU drives alu_out, accepted
// commands push expected responses, and a monitor pops/compares on each response handshake.
module tb_alu_cmd_sequencer;

   logic       clk, rst;
   logic       cmd_valid, cmd_ready;
   logic [7:0] cmd_a, cmd_b;
   logic [3:0] cmd_op;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [3:0] alu_cl;
   logic       rsp_valid, rsp_ready, rsp_err;
   logic [7:0] rsp_data;
   logic [3:0] rsp_op;
   logic [2:0] count;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [12:0] exp_q[$];

   alu_cmd_sequencer #(.DATA_W(8), .OP_W(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cl(alu_cl), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .count(count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
      logic [7:0] r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a * b;
         4'd3:    r = (b == 8'd0) ? 8'd0 : a / b;
         4'd4:    r = a & b;
         4'd5:    r = a | b;
         4'd6:    r = a ^ b;
         4'd7:    r = ~a;
         default: r = a;
      endcase
      return r;
   endfunction

   always_comb alu_out = alu_fn(alu_a, alu_b, alu_cl);

   // Expected response packed as {err, op, data}.
   function automatic logic [12:0] expect_rsp(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] op);
      if (op == 4'd3 && b == 8'd0) return {1'b1, op, 8'hFF};
      return {1'b0, op, alu_fn(a, b, op)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
   endtask

   // Monitor: flush on reset, compare on handshake, require stability while held.
   logic        held = 1'b0;
   logic [12:0] held_v;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         exp_q.delete();
         held = 1'b0;
      end else begin
         if (held) check("hold_stable", 32'({rsp_valid, rsp_err, rsp_op, rsp_data}),
                         32'({1'b1, held_v}));
         held = 1'b0;
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rsp_unexpected: got %0h expected no response",
                        {rsp_err, rsp_op, rsp_data});
            end else begin
               check("rsp", 32'({rsp_err, rsp_op, rsp_data}), 32'(exp_q.pop_front()));
            end
         end else if (rsp_valid === 1'b1) begin
            held   = 1'b1;
            held_v = {rsp_err, rsp_op, rsp_data};
         end
         if (cmd_valid === 1'b1 && cmd_ready === 1'b1)
            exp_q.push_back(expect_rsp(cmd_a, cmd_b, cmd_op));
      end
   end

   task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input logic [7:0] exp_data, input logic exp_err);
      bit seen;
      rsp_ready = 1'b0;
      tick();
      set_cmd(a, b, op);
      tick();
      cmd_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      check("run_one_valid", 32'(seen), 32'd1);
      check("run_one_data", 32'(rsp_data), 32'(exp_data));
      check("run_one_err", 32'(rsp_err), 32'(exp_err));
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      bit done;
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0;

      // Reset
      repeat (2) tick();
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_alu_cl", 32'(alu_cl), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // Single op latency: accepted at T, popped at T+1, valid after T+2
      tick();
      set_cmd(8'd20, 8'd22, 4'd0);
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("lat_t0_valid", 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      check("lat_t1_valid", 32'(rsp_valid), 32'd0);
      check("lat_t1_alu_a", 32'(alu_a), 32'd20);
      tick();
      @(negedge clk);
      check("lat_t2_valid", 32'(rsp_valid), 32'd1);
      check("single_data", 32'(rsp_data), 32'd42);
      check("single_op", 32'(rsp_op), 32'd0);
      check("single_err", 32'(rsp_err), 32'd0);
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Fill: 6 back-to-back, only 5 fit (4 queued + 1 in flight)
      for (int i = 0; i < 6; i++) begin
         set_cmd(8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)));
         tick();
      end
      @(negedge clk);
      check("fill_count", 32'(count), 32'd4);
      check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
      check("fill_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
      @(negedge clk);
      check("fill_held_count", 32'(count), 32'd4);
      tick();
      cmd_valid = 1'b0;

      // Drain: one result every other cycle
      rsp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("drain_valid_%0d", k), 32'(rsp_valid), 32'((k % 2) == 0));
      end
      check("drain_busy", 32'(busy), 32'd0);
      check("drain_count", 32'(count), 32'd0);
      tick();
      rsp_ready = 1'b0;

      // Divide by zero, then a normal divide
      run_one(8'd9, 8'd0, 4'd3, 8'hFF, 1'b1);
      run_one(8'd9, 8'd3, 4'd3, 8'd3, 1'b0);

      // Mid-op reset while HOLD with 3 queued
      for (int i = 0; i < 4; i++) begin
         set_cmd(8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)));
         tick();
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      check("midrst_pre_count", 32'(count), 32'd3);
      check("midrst_pre_valid", 32'(rsp_valid), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(rsp_valid), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      tick();
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("midrst_no_stale", 32'(rsp_valid), 32'd0);
      end

      // Random traffic with random backpressure
      for (int cyc = 0; cyc < 400; cyc++) begin
         tick();
         cmd_valid = ($urandom_range(0, 99) < 60);
         cmd_a     = 8'($urandom);
         cmd_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         cmd_op    = 4'($urandom_range(0, 8));
         rsp_ready = ($urandom_range(0, 99) < 50);
      end
      tick();
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && rsp_valid === 1'b0) done = 1'b1;
      end
      check("final_drained", 32'(done), 32'd1);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
